// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared event codes and per-channel state encoding for the button event scheduler.
// Revision 1.0
`default_nettype none

package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_SHORT = 2'b01,
    EVT_LONG  = 2'b10,
    EVT_LREL  = 2'b11
  } evt_type_t;

  typedef enum logic [1:0] {
    CH_IDLE = 2'b00,
    CH_HELD = 2'b01,
    CH_LONG = 2'b10
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: one channel's press FSM, saturating hold counter and edge-detect register.
// Revision 1.0
`default_nettype none

module btn_press_classifier
  import btn_evt_pkg::*;
#(
  parameter int LONG_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       db,
  output logic       post,
  output logic [1:0] code
);

  localparam int CNT_W = $clog2(LONG_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(LONG_TICKS - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ch_state_t        state;
  ch_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             prev;

  // prev resets high so a button held through reset needs a release first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CH_IDLE;
      cnt   <= '0;
      prev  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= db;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    post      = 1'b0;
    code      = EVT_NONE;
    if (!en) begin
      state_nxt = CH_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        CH_IDLE: begin
          if (db && !prev) begin
            state_nxt = CH_HELD;
            cnt_nxt   = '0;
          end
        end
        CH_HELD: begin
          if (!db) begin
            post      = 1'b1;
            code      = EVT_SHORT;
            state_nxt = CH_IDLE;
          end else begin
            if (cnt != CNT_LAST) cnt_nxt = cnt + CNT_ONE;
            // counter reaching LONG_TICKS-1 on this edge completes LONG_TICKS held samples
            if (cnt == CNT_PRE) begin
              post      = 1'b1;
              code      = EVT_LONG;
              state_nxt = CH_LONG;
            end
          end
        end
        CH_LONG: begin
          if (!db) begin
            post      = 1'b1;
            code      = EVT_LREL;
            state_nxt = CH_IDLE;
          end else if (cnt != CNT_LAST) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_event_scheduler.sv
// button_event_scheduler: classifies N debounced buttons and serialises their events round-robin.
// Revision 1.0
`default_nettype none

module button_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int N          = 4,
  parameter int LONG_TICKS = 50_000_000,
  parameter int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     db_in,
  input  logic [N-1:0]     enable_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_chan,
  output logic [1:0]       evt_type,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [N-1:0]     post;
  logic [1:0]       code  [N];
  logic [N-1:0]     pend;
  logic [1:0]       ptype [N];
  logic [IDX_W-1:0] ptr;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [1:0]       win_type;
  logic [IDX_W-1:0] ptr_nxt;
  logic             load;
  logic             grant;
  logic [N-1:0]     granted;
  logic             ovf_set;

  for (genvar i = 0; i < N; i++) begin : g_chan
    btn_press_classifier #(
      .LONG_TICKS(LONG_TICKS)
    ) u_cls (
      .clk  (clk),
      .reset(reset),
      .en   (enable_mask[i]),
      .db   (db_in[i]),
      .post (post[i]),
      .code (code[i])
    );
  end

  // first pass covers ptr..N-1, second pass wraps to 0..ptr-1
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_type = EVT_NONE;
    for (int i = 0; i < N; i++) begin
      if (!found && pend[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        win      = IDX_W'(i);
        win_type = ptype[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && pend[i]) begin
        found    = 1'b1;
        win      = IDX_W'(i);
        win_type = ptype[i];
      end
    end
  end

  always_comb begin
    load    = !evt_valid || evt_ready;
    grant   = load && found;
    ptr_nxt = (int'(win) == N - 1) ? '0 : win + IDX_ONE;
    granted = '0;
    for (int i = 0; i < N; i++) begin
      granted[i] = grant && (int'(win) == i);
    end
    ovf_set = |(post & pend & ~granted);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      for (int i = 0; i < N; i++) ptype[i] <= EVT_NONE;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!enable_mask[i]) begin
          pend[i] <= 1'b0;
        end else if (post[i]) begin
          pend[i]  <= 1'b1;
          ptype[i] <= code[i];
        end else if (granted[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_type  <= EVT_NONE;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_chan  <= win;
        evt_type  <= win_type;
        ptr       <= ptr_nxt;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

  // set wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler: directed scenarios with a scoreboard of expected event beats.
// Revision 1.0
`default_nettype none

module tb_button_event_scheduler;

  localparam int N          = 4;
  localparam int LONG_TICKS = 16;
  localparam int IDX_W      = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     db_in;
  logic [N-1:0]     enable_mask;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_chan;
  logic [1:0]       evt_type;
  logic             overflow;
  logic             clr_overflow;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  button_event_scheduler #(
    .N         (N),
    .LONG_TICKS(LONG_TICKS),
    .IDX_W     (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db_in       (db_in),
    .enable_mask (enable_mask),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_chan    (evt_chan),
    .evt_type    (evt_type),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input int ch, input logic [1:0] t);
    logic [1:0] c;
    c = 2'(ch);
    exp_q.push_back({c, t});
  endtask

  task automatic press(input int ch, input int hold);
    db_in[ch] = 1'b1;
    repeat (hold) tick();
    db_in[ch] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 60;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b0;
    db_in        = '0;
    enable_mask  = '1;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    repeat (2) tick();
    check({tag, "_valid"}, evt_valid, 0);
    check({tag, "_chan"}, evt_chan, 0);
    check({tag, "_type"}, evt_type, 0);
    check({tag, "_ovf"}, overflow, 0);
    reset = 1'b1;
    repeat (2) tick();
  endtask

  // scoreboard consumer: every accepted beat must match the oldest expected entry
  always @(negedge clk) begin
    if (reset === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_beat: observed chan=%0d type=%0d expected no beat", evt_chan, evt_type);
      end
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({evt_chan, evt_type} === e) else begin
          failures++;
          $error("FAIL beat: observed chan=%0d type=%0d expected chan=%0d type=%0d",
                 evt_chan, evt_type, e[3:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    db_in        = '0;
    enable_mask  = '1;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    #2;

    // 1: short press on ch2, exact latency
    do_reset("rst1");
    db_in[2] = 1'b1;
    repeat (5) tick();
    db_in[2] = 1'b0;
    push_evt(2, 2'b01);
    tick();
    check("s1_valid_early", evt_valid, 0);
    tick();
    check("s1_valid", evt_valid, 1);
    check("s1_chan", evt_chan, 2);
    check("s1_type", evt_type, 2'b01);
    tick();
    check("s1_valid_drop", evt_valid, 0);
    drain("s1_drain");

    // 2: long press on ch1, LONG after 16th held sample then LONG_RELEASE
    db_in[1] = 1'b1;
    push_evt(1, 2'b10);
    push_evt(1, 2'b11);
    repeat (16) tick();
    check("s2_valid_early", evt_valid, 0);
    tick();
    check("s2_valid", evt_valid, 1);
    check("s2_chan", evt_chan, 1);
    check("s2_type", evt_type, 2'b10);
    repeat (23) tick();
    db_in[1] = 1'b0;
    drain("s2_drain");

    // 3: round robin ordering, twice
    do_reset("rst3");
    for (int r = 0; r < 2; r++) begin
      db_in = 4'b1011;
      push_evt(0, 2'b01);
      push_evt(1, 2'b01);
      push_evt(3, 2'b01);
      repeat (3) tick();
      db_in = 4'b0000;
      drain("s3_drain");
    end

    // 4: backpressure and overflow on ch0
    do_reset("rst4");
    evt_ready = 1'b0;
    push_evt(0, 2'b01);
    push_evt(0, 2'b01);
    press(0, 3);
    check("s4_hold_valid", evt_valid, 1);
    check("s4_hold_chan", evt_chan, 0);
    check("s4_hold_type", evt_type, 2'b01);
    press(0, 3);
    check("s4_ovf_pend", overflow, 0);
    check("s4_hold_valid2", evt_valid, 1);
    press(0, 3);
    check("s4_ovf_set", overflow, 1);
    check("s4_hold_type3", evt_type, 2'b01);
    evt_ready = 1'b1;
    drain("s4_drain");
    tick();
    check("s4_valid_idle", evt_valid, 0);
    check("s4_ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("s4_ovf_clr", overflow, 0);

    // 5: reset mid-hold, button held through reset is ignored
    do_reset("rst5");
    evt_ready = 1'b0;
    press(2, 3);
    press(2, 3);
    press(2, 3);
    check("s5_pre_valid", evt_valid, 1);
    check("s5_pre_ovf", overflow, 1);
    db_in[3] = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("s5_rst_valid", evt_valid, 0);
    check("s5_rst_chan", evt_chan, 0);
    check("s5_rst_type", evt_type, 0);
    check("s5_rst_ovf", overflow, 0);
    repeat (2) tick();
    evt_ready = 1'b1;
    reset     = 1'b1;
    repeat (20) tick();
    check("s5_held_novalid", evt_valid, 0);
    db_in[3] = 1'b0;
    repeat (3) tick();
    check("s5_release_novalid", evt_valid, 0);
    push_evt(3, 2'b01);
    press(3, 4);
    drain("s5_drain");

    // 6: disable mid-hold, re-enable while held
    do_reset("rst6");
    db_in[0] = 1'b1;
    repeat (10) tick();
    enable_mask[0] = 1'b0;
    repeat (3) tick();
    db_in[0] = 1'b0;
    repeat (5) tick();
    check("s6_dis_valid", evt_valid, 0);
    check("s6_dis_ovf", overflow, 0);
    db_in[0] = 1'b1;
    tick();
    enable_mask[0] = 1'b1;
    repeat (5) tick();
    db_in[0] = 1'b0;
    repeat (5) tick();
    check("s6_reen_valid", evt_valid, 0);
    push_evt(0, 2'b01);
    press(0, 3);
    drain("s6_drain");
    check("s6_ovf_end", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Sits downstream of the switch/button debouncing array.
- Turns N debounced button levels into classified press events: short press, long press and long-press release.
- Holds one pending event per channel and shares a single event output port between channels through round-robin arbitration with a valid/ready handshake.
- Feeds the control/configuration logic of the detector firmware.

Parameters:
- N, 4, number of debounced channels (N >= 1).
- LONG_TICKS, 50_000_000, hold duration in clk cycles that qualifies a long press (0.5 s at 100 MHz); must be >= 2.
- IDX_W, $clog2(N) with a minimum of 1, width of the channel index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- db_in  in  N  debounced button levels; 1 = pressed.
- enable_mask  in  N  per-channel enable; 0 = channel ignored.
- evt_valid  out  1  event beat available.
- evt_ready  in  1  consumer accepts the beat while evt_valid=1.
- evt_chan  out  IDX_W  channel index of the event.
- evt_type  out  2  event code: 01 SHORT, 10 LONG, 11 LONG_RELEASE (00 never emitted).
- overflow  out  1  sticky flag: a pending event was overwritten.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset asserted (reset=0):
  - evt_valid=0, evt_chan=0, evt_type=00, overflow=0.
  - All channel FSMs go to IDLE, pending flags clear, RR pointer=0.
  - Per-channel previous-level register resets to 1, so a button held through reset is ignored until it is released and pressed again.
- Per-channel FSM, evaluated every clk edge using the sampled db_in[i] and prev[i]:
  - IDLE: db=1 and prev=0 → HELD, hold counter cleared to 0.
  - HELD: counter increments each cycle.
    - db=0 while counter < LONG_TICKS-1 → post SHORT, go to IDLE.
    - Counter reaches LONG_TICKS-1 with db=1 → post LONG, go to LONG.
    - Press of exactly LONG_TICKS cycles is therefore LONG.
  - LONG: db=0 → post LONG_RELEASE, go to IDLE.
  - Counter width is $clog2(LONG_TICKS). It saturates and never wraps.
- enable_mask[i]=0:
  - FSM i is forced to IDLE, its counter to 0 and its pending flag cleared. No event is posted, including mid-hold.
  - Re-enabling needs a fresh rising edge.
- Pending slot (one per channel):
  - A posted event sets pend[i] and ptype[i] on the same edge as the FSM transition.
  - If pend[i] is already set and is not being granted that cycle, ptype[i] is overwritten with the new code and overflow is set.
  - If pend[i] is granted in the same cycle a new event posts: the old event goes to the output, the new one stays pending, and overflow is not set.
- Output register:
  - Loads when it is empty or when evt_valid & evt_ready.
  - Winner is the first pending channel at or after the RR pointer, wrapping from N-1 to 0.
  - On grant, the pointer moves to winner+1 (mod N) and pend[winner] clears.
  - Latency: evt_valid rises on the edge after pend is set, provided the output is free.
  - Back-to-back beats are possible when evt_ready stays 1.
  - evt_chan and evt_type are stable while evt_valid=1 and evt_ready=0.
- overflow:
  - Sticky.
  - clr_overflow clears it on the next edge.
  - A simultaneous set and clear resolves to set.

Decomposition:
- Package btn_evt_pkg holds:
  - enum evt_type_t {EVT_NONE=2'b00, EVT_SHORT=2'b01, EVT_LONG=2'b10, EVT_LREL=2'b11};
  - enum ch_state_t {CH_IDLE, CH_HELD, CH_LONG}.
- Sub-module btn_press_classifier contains one channel's FSM, hold counter and prev register. Its outputs are a post strobe and an event code.
  - It is instantiated N times.
  - Pending slots, the RR arbiter and the output register live in the top.

Test Plan:
All scenarios use N=4 and LONG_TICKS=16.
1. Short press: db_in[2] high for 5 cycles, evt_ready=1 → exactly one beat {chan=2, type=01}; evt_valid rises 2 edges after the first cycle db_in[2] is sampled low.
2. Long press: db_in[1] high for 40 cycles → beat {1,10} after the 16th held cycle, then {1,11} after release; exactly 2 beats in total.
3. Round robin: db_in[0], [1] and [3] pulse high for 3 cycles together, evt_ready=1 → beats ordered chan 0,1,3. Repeating the stimulus gives 0,1,3 again, because the pointer is back at 0.
4. Backpressure and overflow: evt_ready=0, then three short presses on ch0.
   - First press → loaded into the output, held stable.
   - Second press → pending.
   - Third press → overwrites the pending event, overflow=1.
   - Raise evt_ready → 2 beats. Pulse clr_overflow → overflow=0.
5. Reset: assert reset mid-hold on ch3 → all outputs 0 immediately, no event. Release reset with db_in[3] still high → no event until db_in[3] falls and rises again.
6. Disable: clear enable_mask[0] at cycle 10 of a hold on ch0, then release the button → no beat and no overflow. Re-enable with db_in[0]=1 → no event until a new press.
